btb_update_ctrl: RTL
====================

// Module: btb_update_ctrl
// PURPOSE
//  Converts resolved-branch reports from EX into btb write commands (web/waddr/wr_data).
//  Decoupled from EX by a small command FIFO, and drains one command per cycle.
//  Also sequences a full-BTB invalidate sweep on flush_req (e.g. context switch, fence.i).
//  Sits between the EX-stage branch unit and the btb write port.
// PARAMETERS
//  FIFO_DEPTH    4  pending update commands; power of 2, >=2
//  BTB_ADDR_LEN  7  btb index width; must match the btb instance; sweep covers 2**BTB_ADDR_LEN entries
// PORTS
//  clk             in   1   clock
//  rst             in   1   async reset, active-high
//  br_valid        in   1   EX reports a resolved branch/jump this cycle
//  br_ready        out  1   controller accepts report; transfer = br_valid & br_ready
//  br_pc           in   32  PC of resolved instruction
//  br_taken        in   1   actual direction
//  br_target       in   32  actual target (valid when br_taken)
//  br_pred_hit     in   1   btb_hit seen at fetch for this PC
//  br_pred_target  in   32  btb rd_data seen at fetch
//  flush_req       in   1   one-cycle pulse: invalidate whole BTB
//  flush_busy      out  1   drain or sweep in progress
//  flush_done      out  1   one-cycle pulse after last sweep write
//  web             out  2   to btb: 00 none, 01 update target, 10 add, 11 invalidate
//  waddr           out  32  to btb write address
//  wr_data         out  32  to btb write data
//  upd_cnt         out  32  commands issued from FIFO (wraps), excludes sweep writes
//  mispred_cnt     out  32  accepted reports that enqueued a command (wraps)
// BEHAVIOUR
//  Reset: FIFO empty; state IDLE; web=00, waddr=0, wr_data=0.
//   Also at reset: flush_busy=0, flush_done=0, br_ready=1, both counters 0.
//  Classification of an accepted report (cmd = web, br_pc, data):
//   hit & taken & target==pred_target   -> no command
//   hit & taken & target!=pred_target   -> 01, br_target
//   !hit & taken                        -> 10, br_target
//   hit & !taken                        -> 11, 0
//   !hit & !taken                       -> no command
//  br_ready = (state==IDLE) & !full.
//   br_ready is combinational and does not depend on br_valid.
//   A report needing no command is still "accepted"; it leaves no state.
//  Enqueue at the clock edge ending the accept cycle.
//   mispred_cnt +1 on the same edge.
//  Issue: web/waddr/wr_data are combinational from the FIFO head while FIFO non-empty.
//   Otherwise they are 00/0/0, except during SWEEP.
//   The head pops at every edge where it is shown, so each command is shown for exactly 1 cycle.
//   upd_cnt +1 per pop.
//  Latency: report accepted in cycle N -> command on web during N+1 when FIFO was empty.
//   The btb write takes place at the end of N+1.
//  Full FIFO: push and pop in the same cycle are allowed.
//   br_ready stays 0 while full, so a push never coincides with overflow.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM:
//   IDLE -> DRAIN on flush_req.
//    A report accepted in the same cycle as flush_req is still enqueued.
//   DRAIN: br_ready=0; FIFO keeps popping; when empty -> SWEEP with idx=0.
//   SWEEP: web=11, waddr={0, idx[BTB_ADDR_LEN-1:0]}, wr_data=0; idx +1 per cycle.
//    After idx==2**BTB_ADDR_LEN-1 -> IDLE, flush_done=1 for that next cycle.
//  flush_busy = (state!=IDLE).
//  flush_req while flush_busy is ignored; no re-queue.
//  flush_req and a FIFO pop may occur in the same cycle; the pop proceeds normally.
//  rst asserted mid-drain/sweep: immediate return to reset state; partial sweep abandoned.
//  All flops asynchronously reset.
// TESTING
//  !hit & taken, pc=0x100, tgt=0x200, FIFO empty
//   -> next cycle web=10, waddr=0x100, wr_data=0x200; upd_cnt=1, mispred_cnt=1.
//  hit & taken, tgt=pred=0x300
//   -> web stays 00; counters unchanged; br_ready stays 1.
//  hit & !taken, pc=0x140 -> web=11, waddr=0x140 for exactly one cycle.
//  Hold pop path busy, issue 5 back-to-back mispredicts with FIFO_DEPTH=4
//   -> br_ready drops only when full.
//   -> Commands emerge in order, one per cycle, none lost or duplicated.
//  3 commands queued, then flush_req
//   -> 3 commands issued, then 128 cycles of web=11 with waddr 0..127.
//   -> flush_done pulses once; br_ready=0 throughout.
//  rst pulse during SWEEP at idx=40 -> all outputs at reset values; later flush restarts at idx 0.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB update controller: turns resolved-branch reports into BTB write commands through a
// small FIFO that drains one command per cycle, and runs a full-BTB invalidate sweep on flush.
module btb_update_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BTB_ADDR_LEN = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_pred_hit,
    input  logic [31:0] br_pred_target,
    input  logic        flush_req,
    output logic        flush_busy,
    output logic        flush_done,
    output logic [1:0]  web,
    output logic [31:0] waddr,
    output logic [31:0] wr_data,
    output logic [31:0] upd_cnt,
    output logic [31:0] mispred_cnt,
    output logic [1:0]  fsm_state
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;

    localparam logic [1:0] WEB_NONE  = 2'b00;
    localparam logic [1:0] WEB_UPD   = 2'b01;
    localparam logic [1:0] WEB_ADD   = 2'b10;
    localparam logic [1:0] WEB_INVAL = 2'b11;

    // Handshake: a report transfers on any edge where br_valid & br_ready are both high;
    // br_ready depends only on internal state, never on br_valid.

    logic [1:0]              state;
    logic [BTB_ADDR_LEN-1:0] idx;
    logic [1:0]              fifo_web  [FIFO_DEPTH];
    logic [31:0]             fifo_pc   [FIFO_DEPTH];
    logic [31:0]             fifo_data [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW:0]             count;

    logic        empty;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;
    logic [1:0]  cmd_web;
    logic [31:0] cmd_data;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign br_ready   = (state == S_IDLE) && !full;
    assign accept     = br_valid && br_ready;
    assign push       = accept && (cmd_web != WEB_NONE);
    assign pop        = !empty && (state != S_SWEEP);
    assign flush_busy = (state != S_IDLE);
    assign fsm_state  = state;

    // Correct-prediction and not-taken-miss reports need no BTB write.
    always_comb begin
        cmd_web  = WEB_NONE;
        cmd_data = 32'h0;
        if (br_taken) begin
            if (!br_pred_hit) begin
                cmd_web  = WEB_ADD;
                cmd_data = br_target;
            end else if (br_target != br_pred_target) begin
                cmd_web  = WEB_UPD;
                cmd_data = br_target;
            end
        end else if (br_pred_hit) begin
            cmd_web = WEB_INVAL;
        end
    end

    always_comb begin
        web     = WEB_NONE;
        waddr   = 32'h0;
        wr_data = 32'h0;
        if (state == S_SWEEP) begin
            web   = WEB_INVAL;
            waddr = {{(32 - BTB_ADDR_LEN){1'b0}}, idx};
        end else if (!empty) begin
            web     = fifo_web[rd_ptr];
            waddr   = fifo_pc[rd_ptr];
            wr_data = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_web[i]  <= WEB_NONE;
                fifo_pc[i]   <= 32'h0;
                fifo_data[i] <= 32'h0;
            end
        end else if (push) begin
            fifo_web[wr_ptr]  <= cmd_web;
            fifo_pc[wr_ptr]   <= br_pc;
            fifo_data[wr_ptr] <= cmd_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            upd_cnt     <= 32'h0;
            mispred_cnt <= 32'h0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                mispred_cnt <= mispred_cnt + 32'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                upd_cnt <= upd_cnt + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush_req) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_SWEEP;
                        idx   <= '0;
                    end
                end
                S_SWEEP: begin
                    idx <= idx + 1'b1;
                    if (idx == {BTB_ADDR_LEN{1'b1}}) begin
                        state      <= S_IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
